// File: rtl/irrigation_valve_sequencer_pkg.sv
// Shared definitions for the irrigation subsystem.
//   state_t          : sequencer state encoding (IDLE=0, PRIME=1, RUN=2, COOLDOWN=3)
//   DEF_*            : default tick counts and counter width, reused by future
//                      irrigation blocks so every block agrees on the time base.
package irrigation_valve_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam int DEF_PRIME_TICKS     = 2;
  localparam int DEF_SPRINKLER_TICKS = 30;
  localparam int DEF_DRIPPER_TICKS   = 90;
  localparam int DEF_COOLDOWN_TICKS  = 60;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/irrigation_timer.sv
// Tick-gated down-counter used to time each sequencer state.
//   clock, reset : system clock, synchronous active-high reset (count -> 0)
//   load         : load load_value this edge (wins over decrement)
//   load_value   : duration in ticks for the state being entered
//   tick         : time-base enable; count decrements only when high
//   expire       : tick & count==1, i.e. the last tick of the loaded duration
module irrigation_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A load on the entry edge overrides a coincident tick, so that tick is
  // not counted toward the new state. Count parks at zero once drained.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/irrigation_valve_sequencer.sv
// Drives the irrigation valves through prime -> emitter run -> cooldown.
//   clock, reset        : system clock, synchronous active-high reset
//   tick                : one-cycle time-base enable for all durations
//   irrigation_request  : soil dry, start a cycle (level)
//   splinker_mode_on    : 1 = sprinkler, 0 = dripper; latched at PRIME entry
//   low_water_level     : reservoir low; refuses start / aborts a cycle
//   main_valve          : inlet open in PRIME and RUN
//   splinker_valve      : sprinkler emitter open in RUN (sprinkler mode)
//   dripper_valve       : dripper emitter open in RUN (dripper mode)
//   busy                : sequencer not idle
//   water_alarm         : sticky low-water flag, cleared by next good start
module irrigation_valve_sequencer
  import irrigation_valve_sequencer_pkg::*;
#(
  parameter int PRIME_TICKS     = DEF_PRIME_TICKS,
  parameter int SPRINKLER_TICKS = DEF_SPRINKLER_TICKS,
  parameter int DRIPPER_TICKS   = DEF_DRIPPER_TICKS,
  parameter int COOLDOWN_TICKS  = DEF_COOLDOWN_TICKS,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic irrigation_request,
  input  logic splinker_mode_on,
  input  logic low_water_level,
  output logic main_valve,
  output logic splinker_valve,
  output logic dripper_valve,
  output logic busy,
  output logic water_alarm
);

  localparam logic [CNT_W-1:0] PRIME_LD     = CNT_W'(PRIME_TICKS);
  localparam logic [CNT_W-1:0] SPRINKLER_LD = CNT_W'(SPRINKLER_TICKS);
  localparam logic [CNT_W-1:0] DRIPPER_LD   = CNT_W'(DRIPPER_TICKS);
  localparam logic [CNT_W-1:0] COOLDOWN_LD  = CNT_W'(COOLDOWN_TICKS);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             alarm_q, alarm_d;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             expire;

  irrigation_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .tick       (tick),
    .expire     (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      alarm_q <= alarm_d;
    end
  end

  // Next state. Low water in PRIME/RUN aborts regardless of tick and takes
  // precedence over expiry; the mode bit only changes on PRIME entry so a
  // selector change mid-cycle cannot swap emitters.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    alarm_d    = alarm_q;
    load       = 1'b0;
    load_value = '0;
    unique case (state_q)
      IDLE: begin
        if (irrigation_request && !low_water_level) begin
          state_d    = PRIME;
          mode_d     = splinker_mode_on;
          alarm_d    = 1'b0;
          load       = 1'b1;
          load_value = PRIME_LD;
        end else if (irrigation_request) begin
          alarm_d = 1'b1;
        end
      end
      PRIME: begin
        if (low_water_level) begin
          state_d    = COOLDOWN;
          alarm_d    = 1'b1;
          load       = 1'b1;
          load_value = COOLDOWN_LD;
        end else if (expire) begin
          state_d    = RUN;
          load       = 1'b1;
          load_value = mode_q ? SPRINKLER_LD : DRIPPER_LD;
        end
      end
      RUN: begin
        if (low_water_level) begin
          state_d    = COOLDOWN;
          alarm_d    = 1'b1;
          load       = 1'b1;
          load_value = COOLDOWN_LD;
        end else if (expire) begin
          state_d    = COOLDOWN;
          load       = 1'b1;
          load_value = COOLDOWN_LD;
        end
      end
      COOLDOWN: begin
        if (expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode: valves depend only on registered state and mode.
  always_comb begin
    main_valve     = 1'b0;
    splinker_valve = 1'b0;
    dripper_valve  = 1'b0;
    busy           = (state_q != IDLE);
    water_alarm    = alarm_q;
    if (state_q == PRIME) begin
      main_valve = 1'b1;
    end else if (state_q == RUN) begin
      main_valve     = 1'b1;
      splinker_valve = mode_q;
      dripper_valve  = !mode_q;
    end
  end

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Directed bench for irrigation_valve_sequencer with PRIME=2, SPRINKLER=5,
// DRIPPER=8, COOLDOWN=3. Stimulus = {reset,tick,request,mode,low_water};
// expected outputs = {main,splinker,dripper,busy,water_alarm} after the edge.
module tb_irrigation_valve_sequencer;

  logic clock = 1'b0;
  logic reset, tick, irrigation_request, splinker_mode_on, low_water_level;
  logic main_valve, splinker_valve, dripper_valve, busy, water_alarm;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0] stim;
    logic [4:0] expo;
  } vec_t;

  vec_t vecs[$];

  irrigation_valve_sequencer #(
    .PRIME_TICKS     (2),
    .SPRINKLER_TICKS (5),
    .DRIPPER_TICKS   (8),
    .COOLDOWN_TICKS  (3),
    .CNT_W           (8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .tick               (tick),
    .irrigation_request (irrigation_request),
    .splinker_mode_on   (splinker_mode_on),
    .low_water_level    (low_water_level),
    .main_valve         (main_valve),
    .splinker_valve     (splinker_valve),
    .dripper_valve      (dripper_valve),
    .busy               (busy),
    .water_alarm        (water_alarm)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] outs();
    return {main_valve, splinker_valve, dripper_valve, busy, water_alarm};
  endfunction

  task automatic add(input logic [4:0] s, input logic [4:0] e);
    vecs.push_back({s, e});
  endtask

  task automatic drive(input logic [4:0] s);
    {reset, tick, irrigation_request, splinker_mode_on, low_water_level} = s;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {main,spr,drip,busy,alarm} got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    drive(5'b10000);

    // Reset state
    add(5'b10000, 5'b00000);
    // Sprinkler cycle, tick every cycle; request drops after start
    add(5'b01110, 5'b10010);   // PRIME entry, entry tick ignored
    add(5'b01010, 5'b10010);
    add(5'b01010, 5'b11010);   // RUN, sprinkler
    add(5'b01010, 5'b11010);
    add(5'b01010, 5'b11010);
    add(5'b01010, 5'b11010);
    add(5'b01010, 5'b11010);
    add(5'b01010, 5'b00010);   // COOLDOWN
    add(5'b01010, 5'b00010);
    add(5'b01010, 5'b00010);
    add(5'b01010, 5'b00000);   // IDLE
    add(5'b01010, 5'b00000);   // no request, stay IDLE
    // Dripper cycle, selector toggles during RUN
    add(5'b01100, 5'b10010);
    add(5'b01010, 5'b10010);
    add(5'b01010, 5'b10110);   // RUN dripper, 8 ticks
    add(5'b01000, 5'b10110);
    add(5'b01010, 5'b10110);
    add(5'b01000, 5'b10110);
    add(5'b01010, 5'b10110);
    add(5'b01000, 5'b10110);
    add(5'b01010, 5'b10110);
    add(5'b01000, 5'b10110);
    // Request held high through COOLDOWN is ignored there
    add(5'b01100, 5'b00010);
    add(5'b01100, 5'b00010);
    add(5'b01100, 5'b00010);
    add(5'b01100, 5'b00000);   // COOLDOWN exits to IDLE
    add(5'b01110, 5'b10010);   // re-trigger on first IDLE edge
    add(5'b01110, 5'b10010);
    add(5'b01110, 5'b11010);   // RUN sprinkler
    add(5'b01010, 5'b11010);
    add(5'b01010, 5'b11010);   // 2 ticks into RUN
    add(5'b00011, 5'b00011);   // abort without tick
    add(5'b01011, 5'b00011);
    add(5'b01011, 5'b00011);
    add(5'b01011, 5'b00001);   // IDLE, alarm sticky
    add(5'b00111, 5'b00001);   // request refused on low water
    add(5'b00100, 5'b10010);   // good start clears alarm, dripper mode
    add(5'b00000, 5'b10010);   // no tick, count holds
    add(5'b01000, 5'b10010);
    add(5'b01000, 5'b10110);   // RUN dripper
    add(5'b10100, 5'b00000);   // reset mid-RUN closes everything
    add(5'b00100, 5'b10010);   // release with request -> PRIME
    add(5'b10000, 5'b00000);

    foreach (vecs[i]) begin
      drive(vecs[i].stim);
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].expo);
    end

    // Slow time base: tick every 4th clock, entry-edge tick not counted,
    // so PRIME spans 8 clocks.
    drive(5'b01110);
    step();
    check("slow_entry", outs(), 5'b10010);
    for (int c = 1; c <= 8; c++) begin
      drive({1'b0, (c % 4 == 0), 3'b010});
      step();
      check($sformatf("slow_c%0d", c), outs(), (c >= 8) ? 5'b11010 : 5'b10010);
    end

    // Drain back to IDLE within a bounded number of clocks
    drive(5'b01010);
    for (int k = 0; k < 40 && busy; k++) step();
    check("drain_idle", outs(), 5'b00000);

    // Abort from PRIME, then request during COOLDOWN ignored
    drive(5'b00110);
    step();
    check("prime_start", outs(), 5'b10010);
    drive(5'b00011);
    step();
    check("prime_abort", outs(), 5'b00011);
    drive(5'b01110);
    step();
    check("cool_req1", outs(), 5'b00011);
    step();
    check("cool_req2", outs(), 5'b00011);
    step();
    check("cool_exit", outs(), 5'b00001);
    step();
    check("restart_clears", outs(), 5'b10010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
